uart_tx_arbiter: RTL and testbench

Packet-granular round-robin arbiter that shares the single UART transmitter between `NUM_REQ` byte-stream requesters (e.g. core debug print, trace unit, boot monitor). It sits between the requesters and the UART transmitter's `d_in`/`rts`/`next` handshake. A one-entry holding register decouples requester acceptance from UART consumption. A granted requester keeps the UART until it sends a byte flagged `last`, or until `MAX_PKT` bytes have been sent, whichever comes first.

---
 rtl/uart_tx_arbiter_pkg.sv | 14 +
 rtl/uart_tx_arbiter_rr_pick.sv | 29 ++
 rtl/uart_tx_arbiter.sv | 147 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: shared types for the UART TX arbiter slice.
// Byte type, requester ceiling and arbiter FSM state encoding.
package uart_tx_arbiter_pkg;

   typedef logic [7:0] uart_byte_t;

   localparam int UartArbMaxReq = 8;

   typedef enum logic {
      IDLE,
      GRANT
   } uart_arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker. Scans i_req starting
// one past i_last; o_gnt is the one-hot winner, o_found if any.
module rr_pick #(
   parameter int N  = 2,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_last,
   output logic [N-1:0]  o_gnt,
   output logic          o_found
);

   logic [IW-1:0] w_idx;

   always_comb begin
      o_gnt   = '0;
      o_found = 1'b0;
      w_idx   = '0;
      // k = N wraps back to i_last itself, so it has lowest priority
      for (int k = 1; k <= N; k++) begin
         w_idx = IW'((int'(i_last) + k) % N);
         if (!o_found && i_req[w_idx]) begin
            o_gnt[w_idx] = 1'b1;
            o_found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-granular round-robin share of one UART TX.
// Ports: req_valid_i/req_data_i/req_last_i/req_ready_o per requester;
// uart_d_o/uart_rts_o/uart_next_i to the UART; grant_o, busy_o and
// pkt_done_o as status. Sync active-high reset_i on clk_i.
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int MAX_PKT = 64
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic       [NUM_REQ-1:0] req_valid_i,
   input  uart_byte_t [NUM_REQ-1:0] req_data_i,
   input  logic       [NUM_REQ-1:0] req_last_i,
   output logic       [NUM_REQ-1:0] req_ready_o,
   output uart_byte_t               uart_d_o,
   output logic                     uart_rts_o,
   input  logic                     uart_next_i,
   output logic       [NUM_REQ-1:0] grant_o,
   output logic                     busy_o,
   output logic                     pkt_done_o
);

   localparam int IW = $clog2(NUM_REQ);
   localparam logic [7:0] MaxCnt = 8'(MAX_PKT);

   uart_arb_state_e r_state;
   uart_arb_state_e w_next_state;

   logic [NUM_REQ-1:0] r_grant;
   logic [IW-1:0]      r_last_grant;
   logic               r_buf_valid;
   uart_byte_t         r_buf_data;
   logic [7:0]         r_byte_cnt;
   logic               r_pkt_done;

   logic [NUM_REQ-1:0] w_pick;
   logic               w_found;
   logic [IW-1:0]      w_pick_idx;
   logic               w_own_valid;
   logic               w_own_last;
   uart_byte_t         w_own_data;
   logic               w_rdy;
   logic               w_accept;
   logic               w_release;

   rr_pick #(
      .N  (NUM_REQ),
      .IW (IW)
   ) u_pick (
      .i_req   (req_valid_i),
      .i_last  (r_last_grant),
      .o_gnt   (w_pick),
      .o_found (w_found)
   );

   always_comb begin
      w_pick_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_pick[i]) begin
            w_pick_idx = IW'(i);
         end
      end
   end

   // Last winner doubles as the current owner while in GRANT
   assign w_own_valid = req_valid_i[r_last_grant];
   assign w_own_last  = req_last_i[r_last_grant];
   assign w_own_data  = req_data_i[r_last_grant];

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_rdy        = 1'b0;
      w_accept     = 1'b0;
      w_release    = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_found) begin
               w_next_state = GRANT;
            end
         end
         GRANT: begin
            // Slot frees up in the same cycle the UART drains it
            w_rdy     = !r_buf_valid || uart_next_i;
            w_accept  = w_rdy && w_own_valid;
            w_release = w_accept &&
                        (w_own_last ||
                         (r_byte_cnt + 8'd1 == MaxCnt));
            if (w_release) begin
               w_next_state = IDLE;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_grant      <= '0;
         r_last_grant <= IW'(NUM_REQ - 1);
         r_buf_valid  <= 1'b0;
         r_buf_data   <= '0;
         r_byte_cnt   <= '0;
         r_pkt_done   <= 1'b0;
      end else begin
         r_pkt_done <= w_release;

         if (r_state == IDLE && w_found) begin
            r_grant      <= w_pick;
            r_last_grant <= w_pick_idx;
         end else if (w_release) begin
            r_grant <= '0;
         end

         // next with an empty buffer is ignored: clearing is a no-op
         if (w_accept) begin
            r_buf_data  <= w_own_data;
            r_buf_valid <= 1'b1;
         end else if (uart_next_i) begin
            r_buf_valid <= 1'b0;
         end

         if (w_release) begin
            r_byte_cnt <= '0;
         end else if (w_accept) begin
            r_byte_cnt <= r_byte_cnt + 8'd1;
         end
      end
   end

   assign req_ready_o = w_rdy ? r_grant : '0;
   assign grant_o     = r_grant;
   assign uart_rts_o  = r_buf_valid;
   assign uart_d_o    = r_buf_data;
   assign busy_o      = (r_state == GRANT) || r_buf_valid;
   assign pkt_done_o  = r_pkt_done;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench for uart_tx_arbiter with
// NUM_REQ=2 and MAX_PKT=4.
module tb_uart_tx_arbiter;
   import uart_tx_arbiter_pkg::*;

   localparam int N  = 2;
   localparam int MP = 4;

   logic             clk = 1'b0;
   logic             reset_i;
   logic       [N-1:0] req_valid_i;
   uart_byte_t [N-1:0] req_data_i;
   logic       [N-1:0] req_last_i;
   logic       [N-1:0] req_ready_o;
   uart_byte_t       uart_d_o;
   logic             uart_rts_o;
   logic             uart_next_i;
   logic       [N-1:0] grant_o;
   logic             busy_o;
   logic             pkt_done_o;

   int checks = 0;
   int errors = 0;
   logic [7:0] cap[$];
   int pulses;

   logic [7:0] fair_exp[8] = '{8'hB0, 8'hB1, 8'hA0, 8'hA1,
                               8'hB0, 8'hB1, 8'hA0, 8'hA1};
   logic [7:0] frc_exp[7]  = '{8'h01, 8'h02, 8'h03, 8'h04,
                               8'hC0, 8'h05, 8'h06};

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .NUM_REQ (N),
      .MAX_PKT (MP)
   ) dut (
      .clk_i       (clk),
      .reset_i     (reset_i),
      .req_valid_i (req_valid_i),
      .req_data_i  (req_data_i),
      .req_last_i  (req_last_i),
      .req_ready_o (req_ready_o),
      .uart_d_o    (uart_d_o),
      .uart_rts_o  (uart_rts_o),
      .uart_next_i (uart_next_i),
      .grant_o     (grant_o),
      .busy_o      (busy_o),
      .pkt_done_o  (pkt_done_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Requesters stream bytes base+offset; UART takes one per cycle.
   task automatic stream(input int lim0, input int lim1,
                         input int plen0, input int plen1,
                         input int base0, input int base1,
                         input int want);
      int lim[N];
      int plen[N];
      int base[N];
      int cnt[N];
      int off;
      logic [N-1:0] acc;
      lim[0] = lim0;   lim[1] = lim1;
      plen[0] = plen0; plen[1] = plen1;
      base[0] = base0; base[1] = base1;
      cnt[0] = 0;      cnt[1] = 0;
      cap.delete();
      pulses = 0;
      uart_next_i = 1'b1;
      for (int cyc = 0; cyc < 80 && cap.size() < want; cyc++) begin
         for (int i = 0; i < N; i++) begin
            off = (plen[i] != 0) ? cnt[i] % plen[i] : cnt[i];
            req_valid_i[i] = cnt[i] < lim[i];
            req_data_i[i]  = 8'(base[i] + off);
            req_last_i[i]  = (plen[i] != 0) && (off == plen[i] - 1);
         end
         #1;
         acc = req_valid_i & req_ready_o;
         if (uart_rts_o && uart_next_i) cap.push_back(uart_d_o);
         if (pkt_done_o) pulses++;
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            if (acc[i]) cnt[i]++;
         end
      end
      req_valid_i = '0;
      req_last_i  = '0;
   endtask

   initial begin
      reset_i     = 1'b1;
      req_valid_i = '0;
      req_data_i  = '0;
      req_last_i  = '0;
      uart_next_i = 1'b0;
      tick();
      tick();
      reset_i = 1'b0;
      chk("rst_grant", grant_o, 0);
      chk("rst_rts", uart_rts_o, 0);
      chk("rst_d", uart_d_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", pkt_done_o, 0);
      chk("rst_ready", req_ready_o, 0);

      // Single packet 0x48, 0x69(last) from requester 0
      req_valid_i   = 2'b01;
      req_data_i[0] = 8'h48;
      tick();
      chk("sp_grant", grant_o, 2'b01);
      chk("sp_rts0", uart_rts_o, 0);
      chk("sp_ready", req_ready_o, 2'b01);
      tick();
      chk("sp_rts1", uart_rts_o, 1);
      chk("sp_d48", uart_d_o, 8'h48);
      req_data_i[0] = 8'h69;
      req_last_i[0] = 1'b1;
      #1;
      chk("sp_full_ready", req_ready_o, 2'b00);
      repeat (4) tick();
      chk("sp_hold_d", uart_d_o, 8'h48);
      chk("sp_hold_rts", uart_rts_o, 1);
      uart_next_i = 1'b1;
      #1;
      chk("sp_next_ready", req_ready_o, 2'b01);
      tick();
      chk("sp_d69", uart_d_o, 8'h69);
      chk("sp_done", pkt_done_o, 1);
      chk("sp_rel_grant", grant_o, 0);
      chk("sp_busy_buf", busy_o, 1);
      req_valid_i = '0;
      req_last_i  = '0;
      uart_next_i = 1'b0;
      tick();
      chk("sp_done_1cyc", pkt_done_o, 0);
      chk("sp_kept", uart_rts_o, 1);
      uart_next_i = 1'b1;
      tick();
      chk("sp_drained", uart_rts_o, 0);
      chk("sp_idle_busy", busy_o, 0);
      uart_next_i = 1'b0;

      // Fairness, back-to-back: requester 1 goes first after 0
      stream(4, 4, 2, 2, 'hA0, 'hB0, 8);
      chk("fair_count", cap.size(), 8);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("fair_byte%0d", i),
             (i < cap.size()) ? 32'(cap[i]) : 32'hDEAD,
             fair_exp[i]);
      end
      chk("fair_pulses", pulses, 4);
      chk("fair_idle", grant_o, 0);

      // Forced release after MAX_PKT bytes from requester 1
      stream(1, 6, 1, 0, 'hC0, 'h01, 7);
      chk("frc_count", cap.size(), 7);
      for (int i = 0; i < 7; i++) begin
         chk($sformatf("frc_byte%0d", i),
             (i < cap.size()) ? 32'(cap[i]) : 32'hDEAD,
             frc_exp[i]);
      end
      chk("frc_pulses", pulses, 2);
      chk("frc_held", grant_o, 2'b10);
      chk("frc_busy", busy_o, 1);
      chk("frc_rts", uart_rts_o, 0);

      // Reset while a byte is held
      uart_next_i   = 1'b0;
      req_valid_i   = 2'b10;
      req_data_i[1] = 8'h07;
      #1;
      chk("mr_ready", req_ready_o, 2'b10);
      tick();
      chk("mr_held", uart_rts_o, 1);
      chk("mr_d07", uart_d_o, 8'h07);
      req_valid_i = '0;
      reset_i     = 1'b1;
      tick();
      reset_i = 1'b0;
      chk("mr_grant", grant_o, 0);
      chk("mr_rts", uart_rts_o, 0);
      chk("mr_d", uart_d_o, 0);
      chk("mr_busy", busy_o, 0);
      chk("mr_done", pkt_done_o, 0);
      chk("mr_ready0", req_ready_o, 0);

      // Stall: owner 0 pauses mid-packet, requester 1 waits
      req_valid_i   = 2'b11;
      req_data_i[0] = 8'h31;
      req_data_i[1] = 8'h41;
      req_last_i    = 2'b10;
      tick();
      chk("st_first", grant_o, 2'b01);
      chk("st_ready", req_ready_o, 2'b01);
      tick();
      chk("st_d31", uart_d_o, 8'h31);
      req_valid_i = 2'b10;
      uart_next_i = 1'b1;
      tick();
      chk("st_drain", uart_rts_o, 0);
      uart_next_i = 1'b0;
      repeat (20) tick();
      chk("st_hold", grant_o, 2'b01);
      chk("st_hold_rdy", req_ready_o, 2'b01);
      chk("st_hold_busy", busy_o, 1);
      req_valid_i   = 2'b11;
      req_data_i[0] = 8'h32;
      req_last_i    = 2'b11;
      tick();
      chk("st_d32", uart_d_o, 8'h32);
      chk("st_done", pkt_done_o, 1);
      chk("st_rel", grant_o, 0);
      req_valid_i = 2'b10;
      tick();
      chk("st_g1", grant_o, 2'b10);
      chk("st_g1_full", req_ready_o, 2'b00);
      uart_next_i = 1'b1;
      #1;
      chk("st_g1_rdy", req_ready_o, 2'b10);
      tick();
      chk("st_d41", uart_d_o, 8'h41);
      chk("st_d41_rts", uart_rts_o, 1);
      chk("st_done1", pkt_done_o, 1);
      req_valid_i = '0;
      req_last_i  = '0;
      tick();
      chk("st_end_rts", uart_rts_o, 0);
      chk("st_end_busy", busy_o, 0);
      uart_next_i = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
